// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks A+B+Cin from LSB to MSB,
// one bit per clock, with valid/ready handshakes on both sides.

module serial_add_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

  logic fa_s, fa_co;

  serial_add_fa u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      c_msb_q   <= 1'b0;
      cout_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      c_msb_q   <= c_msb_d;
      cout_q    <= cout_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    c_msb_d   = c_msb_q;
    cout_d    = cout_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d    = A;
          b_sh_d    = B;
          carry_d   = Cin;
          bit_cnt_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        sum_sh_d  = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d   = fa_co;
        bit_cnt_d = bit_cnt_q + CW'(1);
        // Last bit: the carry register still holds the carry into the MSB.
        if (bit_cnt_q == CW'(WIDTH-1)) begin
          c_msb_d = carry_q;
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = c_msb_q ^ cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): arithmetic corners, latency,
// backpressure, mid-run reset and back-to-back throughput.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;
  logic         busy;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One add with hand-computed expectations; result consumed right away.
  task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    A = a; B = b; Cin = ci; in_valid = 1'b1;
    step();
    in_valid = 1'b0; A = ~a; B = ~b; Cin = ~ci;
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, W);
    chk({tag, "_sum"}, Sum, es);
    chk({tag, "_cout"}, Cout, ec);
    chk({tag, "_ovf"}, Ovf, eo);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, es, hs;
    logic         rc, ec, eo, hc, ho, seen;
    logic [W:0]   full;
    int           prev_acc, acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_cout", Cout, 0);
    chk("rst_ovf", Ovf, 0);

    do_add("posovf", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    do_add("wrap1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add("wrap2",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_add("cin0",   8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    do_add("cinff",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Backpressure: 0x7F+0x01 = 0x80, Cout=0, Ovf=1; hold DONE five cycles.
    A = 8'h7F; B = 8'h01; Cin = 1'b0; in_valid = 1'b1;
    step();
    A = 8'h00; B = 8'h00;
    for (int i = 0; i < W; i++) step();
    for (int i = 0; i < 5; i++) begin
      A = 8'(i * 37); B = 8'(i * 91); Cin = i[0];
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", Sum, 8'h80);
      chk("bp_cout", Cout, 0);
      chk("bp_ovf", Ovf, 1);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);

    // Reset while bit_cnt==3 aborts the add.
    A = 8'hC3; B = 8'h5C; Cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_in_ready", in_ready, 1);
    chk("mid_busy0", busy, 0);
    chk("mid_valid", out_valid, 0);
    chk("mid_sum", Sum, 0);
    chk("mid_cout", Cout, 0);
    chk("mid_ovf", Ovf, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("mid_no_pulse", seen, 0);

    // Back-to-back with in_valid/out_ready tied high; bus carries junk outside IDLE.
    in_valid = 1'b1; out_ready = 1'b1;
    prev_acc = 0;
    for (int k = 0; k < 16; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      es = full[W-1:0];
      ec = full[W];
      eo = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
      A = ra; B = rb; Cin = rc;
      step();
      acc = cyc;
      if (k > 0) chk("b2b_spacing", acc - prev_acc, W + 2);
      prev_acc = acc;
      for (int i = 0; i < W; i++) begin
        A = 8'($urandom_range(0, 255)); B = 8'($urandom_range(0, 255));
        Cin = 1'($urandom_range(0, 1));
        hs = Sum; hc = Cout; ho = Ovf;
        step();
        if (i < W - 1) begin
          chk("b2b_hold", {hs, hc, ho}, {Sum, Cout, Ovf});
        end
      end
      chk("b2b_valid", out_valid, 1);
      chk("b2b_sum", Sum, es);
      chk("b2b_cout", Cout, ec);
      chk("b2b_ovf", Ovf, eo);
      A = ~ra; B = ~rb;
      step();
      chk("b2b_idle", in_ready, 1);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
